instr_mem_resp: RTL and testbench

//  Responder for the fetch stage's instruction read interface. Samples pc while

---
 rtl/instr_mem_resp.sv | 89 ++++++++
 tb/tb_instr_mem_resp.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_resp.sv
// Instruction-read responder for the fetch stage: local RAM, fixed wait states,
// branch flush and a side-band preload port.
module instr_mem_resp #(
  parameter int XLEN        = 32,
  parameter int DEPTH_LOG2  = 10,
  parameter int WAIT_STATES = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_read_en,
  input  logic [XLEN-1:0]       pc,
  input  logic                  branch_taken,
  output logic                  halt,
  output logic [31:0]           instr,
  output logic                  instr_valid,
  output logic [XLEN-1:0]       instr_pc,
  output logic                  addr_fault,
  input  logic                  ld_en,
  input  logic [DEPTH_LOG2-1:0] ld_addr,
  input  logic [31:0]           ld_data
);

  localparam int          DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [2:0]  WAIT_CNT = 3'(WAIT_STATES);
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef enum logic {IDLE, BUSY} state_e;

  state_e          r_state;
  logic [2:0]      r_cnt;
  logic [XLEN-1:0] r_req_pc;
  logic [31:0]     r_mem [DEPTH];

  logic                  w_counting;
  logic                  w_respond;
  logic                  w_fault;
  logic [DEPTH_LOG2-1:0] w_word_idx;
  logic [31:0]           w_rd_data;

  assign w_counting = (r_state == BUSY) && (r_cnt != 3'd0);
  assign w_respond  = (r_state == BUSY) && (r_cnt == 3'd0);
  assign w_word_idx = r_req_pc[DEPTH_LOG2+1:2];
  assign w_fault    = (r_req_pc[1:0] != 2'b00) || ((r_req_pc >> (DEPTH_LOG2 + 2)) != '0);
  assign w_rd_data  = r_mem[w_word_idx];

  // A flush releases fetch in the same cycle so the branch target can be taken.
  assign halt = w_counting && !branch_taken;

  // NOTE: the RAM sits in its own clocked block with no reset; memories are not
  // cleared, and a same-edge write leaves the response read seeing the old word.
  always_ff @(posedge clk) begin
    if (ld_en) r_mem[ld_addr] <= ld_data;
  end

  // NOTE: all state updates are non-blocking, so every term below sees the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= 3'd0;
      r_req_pc    <= '0;
      instr       <= 32'd0;
      instr_valid <= 1'b0;
      instr_pc    <= '0;
      addr_fault  <= 1'b0;
    end else begin
      instr_valid <= 1'b0;

      if (w_respond && !branch_taken) begin
        instr_valid <= 1'b1;
        instr_pc    <= r_req_pc;
        instr       <= w_fault ? NOP : w_rd_data;
        addr_fault  <= w_fault;
      end

      // A request still counting ignores read_en; anything else may re-accept.
      if (w_counting && !branch_taken) begin
        r_cnt <= r_cnt - 3'd1;
      end else if (instr_read_en) begin
        r_req_pc <= pc;
        r_cnt    <= WAIT_CNT;
        r_state  <= BUSY;
      end else begin
        r_state <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_resp.sv
// Three responders (WAIT_STATES 0, 1, 3) share one stimulus stream; a
// transaction-level model predicts responses into a scoreboard queue.
module tb_instr_mem_resp;

  localparam int LANES = 3;

  typedef struct {
    int          lane;
    logic [31:0] instr;
    logic [31:0] pc;
    logic        fault;
    int          edge_n;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        instr_read_en;
  logic [31:0] pc;
  logic        branch_taken;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  logic        halt_o   [LANES];
  logic [31:0] instr_o  [LANES];
  logic        valid_o  [LANES];
  logic [31:0] ipc_o    [LANES];
  logic        fault_o  [LANES];

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    instr_mem_resp #(
      .XLEN       (32),
      .DEPTH_LOG2 (10),
      .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 1 : 3))
    ) u_dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr_read_en(instr_read_en),
      .pc           (pc),
      .branch_taken (branch_taken),
      .halt         (halt_o[g]),
      .instr        (instr_o[g]),
      .instr_valid  (valid_o[g]),
      .instr_pc     (ipc_o[g]),
      .addr_fault   (fault_o[g]),
      .ld_en        (ld_en),
      .ld_addr      (ld_addr),
      .ld_data      (ld_data)
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  bit          started = 1'b0;
  exp_t        exp_q[$];
  logic [31:0] ref_mem [1024];
  bit          pend_v   [LANES];
  logic [31:0] pend_pc  [LANES];
  int          pend_due [LANES];

  function automatic int wait_of(int l);
    return (l == 0) ? 0 : ((l == 1) ? 1 : 3);
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string tag);
    for (int l = 0; l < LANES; l++) begin
      check($sformatf("%s_instr_l%0d", tag, l), 64'(instr_o[l]), 64'd0);
      check($sformatf("%s_valid_l%0d", tag, l), 64'(valid_o[l]), 64'd0);
      check($sformatf("%s_pc_l%0d", tag, l), 64'(ipc_o[l]), 64'd0);
      check($sformatf("%s_fault_l%0d", tag, l), 64'(fault_o[l]), 64'd0);
      check($sformatf("%s_halt_l%0d", tag, l), 64'(halt_o[l]), 64'd0);
    end
  endtask

  // One clock cycle: apply inputs, check halt, advance the model over the edge.
  task automatic drive(input logic rd, input logic [31:0] p, input logic br,
                       input logic le, input logic [9:0] la, input logic [31:0] ld);
    logic f;
    instr_read_en = rd;
    pc            = p;
    branch_taken  = br;
    ld_en         = le;
    ld_addr       = la;
    ld_data       = ld;
    #1;
    for (int l = 0; l < LANES; l++) begin
      check($sformatf("halt_l%0d", l), 64'(halt_o[l]),
            64'(pend_v[l] && (cyc < pend_due[l]) && !br));
      if (br) pend_v[l] = 1'b0;
      if (pend_v[l] && pend_due[l] == cyc) begin
        f = (pend_pc[l] % 4 != 0) || (pend_pc[l] >= 32'h1000);
        exp_q.push_back('{lane: l, instr: f ? 32'h13 : ref_mem[pend_pc[l][11:2]],
                          pc: pend_pc[l], fault: f, edge_n: cyc});
        pend_v[l] = 1'b0;
      end
      if (rd && !pend_v[l]) begin
        pend_v[l]   = 1'b1;
        pend_pc[l]  = p;
        pend_due[l] = cyc + wait_of(l) + 1;
      end
    end
    if (le) ref_mem[la] = ld;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic fetch(input logic [31:0] p);
    drive(1'b1, p, 1'b0, 1'b0, 10'd0, 32'd0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'd0, 1'b0, 1'b0, 10'd0, 32'd0);
  endtask

  task automatic pulse_reset();
    instr_read_en = 1'b0;
    branch_taken  = 1'b0;
    ld_en         = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("mid_reset");
    for (int l = 0; l < LANES; l++) pend_v[l] = 1'b0;
    #1 rst_n = 1'b1;
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (started && rst_n) begin
      for (int l = 0; l < LANES; l++) begin
        int idx;
        idx = -1;
        foreach (exp_q[i]) if (idx < 0 && exp_q[i].lane == l) idx = i;
        if (valid_o[l]) begin
          if (idx < 0) begin
            check($sformatf("unexpected_valid_l%0d", l), 64'd1, 64'd0);
          end else begin
            check($sformatf("instr_l%0d", l), 64'(instr_o[l]), 64'(exp_q[idx].instr));
            check($sformatf("instr_pc_l%0d", l), 64'(ipc_o[l]), 64'(exp_q[idx].pc));
            check($sformatf("fault_l%0d", l), 64'(fault_o[l]), 64'(exp_q[idx].fault));
            check($sformatf("resp_edge_l%0d", l), 64'(cyc - 1), 64'(exp_q[idx].edge_n));
            exp_q.delete(idx);
          end
        end else if (idx >= 0 && exp_q[idx].edge_n < cyc) begin
          check($sformatf("missing_valid_l%0d", l), 64'd0, 64'd1);
          exp_q.delete(idx);
        end
      end
    end
  end

  initial begin
    logic [31:0] p;
    int          r;
    rst_n         = 1'b0;
    instr_read_en = 1'b0;
    pc            = 32'd0;
    branch_taken  = 1'b0;
    ld_en         = 1'b0;
    ld_addr       = 10'd0;
    ld_data       = 32'd0;
    for (int l = 0; l < LANES; l++) pend_v[l] = 1'b0;
    #12 rst_n = 1'b1;
    @(negedge clk);
    check_zero("reset");
    started = 1'b1;

    for (int i = 0; i < 32; i++)
      drive(1'b0, 32'd0, 1'b0, 1'b1, 10'(i), (i < 4) ? 32'hA000_0000 + 32'(i) : $urandom());

    // Fetch holds each pc across the single wait state of the middle lane.
    fetch(32'h0); fetch(32'h0); fetch(32'h4); fetch(32'h4); fetch(32'h8); fetch(32'h8);
    idle(5);

    fetch(32'h0); fetch(32'h4); fetch(32'h8); fetch(32'hC);
    idle(5);

    // Flush on the second wait edge of the WAIT_STATES=3 lane, redirect to 0x40.
    fetch(32'h8);
    idle(1);
    drive(1'b1, 32'h40, 1'b1, 1'b0, 10'd0, 32'd0);
    idle(6);

    fetch(32'h6);
    idle(5);
    fetch(32'h1000);
    idle(5);

    // Overwrite word 2 on the edge the WAIT_STATES=1 lane returns it.
    fetch(32'h8);
    idle(1);
    drive(1'b0, 32'd0, 1'b0, 1'b1, 10'd2, 32'hB000_0002);
    idle(4);
    fetch(32'h8);
    idle(5);

    fetch(32'h0);
    pulse_reset();
    fetch(32'h0);
    idle(5);

    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0)      p = ($urandom_range(0, 31) << 2) | $urandom_range(1, 3);
      else if (r == 1) p = 32'h1000 | $urandom();
      else             p = $urandom_range(0, 31) << 2;
      drive($urandom_range(0, 3) != 0, p, $urandom_range(0, 9) == 0,
            $urandom_range(0, 6) == 0, 10'($urandom_range(0, 31)), $urandom());
    end
    idle(8);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
